tc_delay_line_arbiter: RTL and testbench

Shares one programmable-depth delay pipeline among several requesters. Each cycle it grants at most one requester in round-robin order. The granted word, tagged with its requester index, is pushed into the pipeline and emerges a configured number of cycles later. The block also sequences delay reconfiguration: it stops granting, drains in-flight words, and only then applies the new depth. It sits between requester-side datapath components and a single consumer of delayed data.

---
 rtl/tc_delay_line_arbiter.sv | 160 ++++++++++++++++
 tb/tb_tc_delay_line_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tc_delay_line_arbiter.sv
// Round-robin arbiter feeding one shared, programmable-depth delay pipeline.
// A depth change waits until every in-flight word has drained.
module tc_delay_line_arbiter #(
    parameter int BIT_WIDTH  = 8,
    parameter int REQUESTERS = 4,
    parameter int MAX_DELAY  = 8,
    parameter int TAG_W      = $clog2(REQUESTERS),
    parameter int CNT_W      = $clog2(MAX_DELAY + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [REQUESTERS-1:0]           req,
    input  logic [REQUESTERS*BIT_WIDTH-1:0] in_data,
    output logic [REQUESTERS-1:0]           grant,
    input  logic [CNT_W-1:0]                cfg_delay,
    input  logic                            cfg_load,
    output logic                            out_valid,
    output logic [BIT_WIDTH-1:0]            out_data,
    output logic [TAG_W-1:0]                out_tag,
    output logic                            busy
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                 state_reg;
    logic [TAG_W-1:0]       rr_reg;
    logic [CNT_W-1:0]       delay_reg;
    logic [CNT_W-1:0]       pending_reg;
    logic [CNT_W-1:0]       count_reg;
    logic [CNT_W-1:0]       count_next;
    logic [CNT_W-1:0]       tap;
    logic [CNT_W-1:0]       cfg_clamped;
    logic [MAX_DELAY-1:0]   valid_reg;
    logic [TAG_W-1:0]       tag_reg  [MAX_DELAY];
    logic [BIT_WIDTH-1:0]   data_reg [MAX_DELAY];

    logic [REQUESTERS-1:0]  hi_mask;
    logic [REQUESTERS-1:0]  masked;
    logic [REQUESTERS-1:0]  cand;
    logic                   allow;
    logic                   accept;
    logic [TAG_W-1:0]       acc_tag;
    logic [BIT_WIDTH-1:0]   acc_data;

    always_comb begin
        cfg_clamped = cfg_delay;
        if (cfg_delay == '0) begin
            cfg_clamped = CNT_W'(1);
        end else if (cfg_delay > CNT_W'(MAX_DELAY)) begin
            cfg_clamped = CNT_W'(MAX_DELAY);
        end
    end

    // Requesters at or above the rr pointer get first pick; otherwise wrap.
    generate
        for (genvar gi = 0; gi < REQUESTERS; gi++) begin : g_mask
            assign hi_mask[gi] = (TAG_W'(gi) >= rr_reg);
        end
    endgenerate

    always_comb begin
        allow  = (state_reg != DRAIN) && !cfg_load;
        masked = req & hi_mask;
        cand   = (masked != '0) ? masked : req;
        // Isolate the lowest set bit of the candidate set.
        grant  = allow ? (cand & (~cand + REQUESTERS'(1))) : '0;
    end

    assign accept = |grant;

    always_comb begin
        acc_tag  = '0;
        acc_data = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (grant[i]) begin
                acc_tag  = TAG_W'(i);
                acc_data = in_data[i*BIT_WIDTH +: BIT_WIDTH];
            end
        end
    end

    assign tap = delay_reg - CNT_W'(1);

    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_tag   = '0;
        for (int i = 0; i < MAX_DELAY; i++) begin
            if ((CNT_W'(i) == tap) && valid_reg[i]) begin
                out_valid = 1'b1;
                out_data  = data_reg[i];
                out_tag   = tag_reg[i];
            end
        end
    end

    assign count_next = count_reg + CNT_W'(accept) - CNT_W'(out_valid);
    assign busy       = (state_reg != IDLE);

    // Words past the tap are invalidated so a later, deeper setting never sees them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_reg <= '0;
            for (int i = 0; i < MAX_DELAY; i++) begin
                tag_reg[i]  <= '0;
                data_reg[i] <= '0;
            end
        end else begin
            valid_reg[0] <= accept;
            tag_reg[0]   <= acc_tag;
            data_reg[0]  <= acc_data;
            for (int i = 1; i < MAX_DELAY; i++) begin
                valid_reg[i] <= valid_reg[i-1] && (tap != CNT_W'(i-1));
                tag_reg[i]   <= tag_reg[i-1];
                data_reg[i]  <= data_reg[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            rr_reg      <= '0;
            count_reg   <= '0;
            delay_reg   <= CNT_W'(1);
            pending_reg <= CNT_W'(1);
        end else begin
            count_reg <= count_next;
            if (accept) begin
                rr_reg <= (acc_tag == TAG_W'(REQUESTERS-1)) ? '0 : acc_tag + TAG_W'(1);
            end
            case (state_reg)
                IDLE: begin
                    if (cfg_load) begin
                        delay_reg <= cfg_clamped;
                    end else if (accept) begin
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    if (cfg_load) begin
                        state_reg   <= DRAIN;
                        pending_reg <= cfg_clamped;
                    end else if (count_next == '0) begin
                        state_reg <= IDLE;
                    end
                end
                DRAIN: begin
                    if (cfg_load) begin
                        pending_reg <= cfg_clamped;
                    end
                    if (count_reg == '0) begin
                        state_reg <= IDLE;
                        delay_reg <= pending_reg;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tc_delay_line_arbiter.sv
// Bench for tc_delay_line_arbiter: random and directed stimulus against an
// emission-schedule reference model.
module tb_tc_delay_line_arbiter;
    localparam int R    = 4;
    localparam int W    = 8;
    localparam int MAXD = 8;
    localparam int TW   = $clog2(R);
    localparam int CW   = $clog2(MAXD + 1);
    localparam int VW   = R + W + TW + 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [R-1:0]   req = '0;
    logic [R*W-1:0] in_data = '0;
    logic [R-1:0]   grant;
    logic [CW-1:0]  cfg_delay = '0;
    logic           cfg_load = 1'b0;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [TW-1:0]  out_tag;
    logic           busy;

    int errors = 0;
    int checks = 0;

    tc_delay_line_arbiter #(
        .BIT_WIDTH(W), .REQUESTERS(R), .MAX_DELAY(MAXD), .TAG_W(TW), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .in_data(in_data), .grant(grant),
        .cfg_delay(cfg_delay), .cfg_load(cfg_load), .out_valid(out_valid),
        .out_data(out_data), .out_tag(out_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: each accepted word is scheduled for an absolute cycle.
    typedef struct {
        int            cyc;
        logic [W-1:0]  data;
        logic [TW-1:0] tag;
    } em_t;
    em_t q[$];
    int  m_rr, m_d, m_pend, m_mode, m_c;   // m_mode: 0 idle, 1 run, 2 drain

    logic [R-1:0]  g_obs, g_exp;
    logic          exp_valid, exp_busy;
    logic [W-1:0]  exp_data;
    logic [TW-1:0] exp_tag;

    function automatic int mclamp(input int v);
        if (v < 1) return 1;
        if (v > MAXD) return MAXD;
        return v;
    endfunction

    function automatic logic [R-1:0] model_grant(input logic [R-1:0] r, input logic ld);
        if (m_mode == 2 || ld || r == '0) return '0;
        for (int k = 0; k < R; k++) begin
            int i;
            i = (m_rr + k) % R;
            if (r[i]) return R'(1) << i;
        end
        return '0;
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {g_obs, out_valid, out_data, out_tag, busy};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {g_exp, exp_valid, exp_data, exp_tag, exp_busy};
    endfunction

    task automatic model_reset();
        q.delete();
        m_rr = 0; m_d = 1; m_pend = 1; m_mode = 0;
    endtask

    // One clock: drive at negedge, sample grant, advance model at posedge,
    // leave expected outputs ready at the following negedge.
    task automatic cycle(input logic [R-1:0] r, input logic [R*W-1:0] din,
                         input logic ld, input logic [CW-1:0] cd);
        int cnt_now, sel;
        req = r; in_data = din; cfg_load = ld; cfg_delay = cd;
        #1;
        g_obs = grant;
        g_exp = model_grant(r, ld);
        @(posedge clk);
        cnt_now = q.size();
        while (q.size() > 0 && q[0].cyc <= m_c) void'(q.pop_front());
        if (g_exp != '0) begin
            sel = 0;
            for (int i = 0; i < R; i++) if (g_exp[i]) sel = i;
            q.push_back('{m_c + m_d, W'(din >> (sel*W)), TW'(sel)});
            m_rr = (sel + 1) % R;
            $display("acc cyc=%0d tag=%0d data=%h d=%0d", m_c + 1, sel, W'(din >> (sel*W)), m_d);
        end
        case (m_mode)
            0: if (ld) m_d = mclamp(int'(cd)); else if (g_exp != '0) m_mode = 1;
            1: if (ld) begin m_mode = 2; m_pend = mclamp(int'(cd)); end
               else if (q.size() == 0) m_mode = 0;
            default: begin
                if (cnt_now == 0) begin m_mode = 0; m_d = m_pend; end
                if (ld) m_pend = mclamp(int'(cd));
            end
        endcase
        m_c++;
        @(negedge clk);
        exp_valid = 1'b0; exp_data = '0; exp_tag = '0;
        if (q.size() > 0 && q[0].cyc == m_c) begin
            exp_valid = 1'b1; exp_data = q[0].data; exp_tag = q[0].tag;
        end
        exp_busy = (m_mode != 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        if ({out_valid, out_data, out_tag, busy, grant} !== '0) begin
            errors++;
            $display("FAIL reset got v=%b d=%h t=%0d busy=%b g=%b exp all zero",
                     out_valid, out_data, out_tag, busy, grant);
        end
        checks++;
        model_reset();
        m_c = 0;
        #9 rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        for (int n = 0; n < 8; n++) begin
            cycle('1, $urandom, 1'b0, '0);
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rr_model cyc=%0d got=%h exp=%h", m_c, obs_vec(), exp_vec());
            end
            checks++;
            if (g_obs !== (R'(1) << (n % R)) || out_valid !== 1'b1 || out_tag !== TW'(n % R)) begin
                errors++;
                $display("FAIL rr_seq n=%0d got g=%b v=%b t=%0d exp g=%b v=1 t=%0d",
                         n, g_obs, out_valid, out_tag, R'(1) << (n % R), n % R);
            end
            checks++;
        end
        for (int n = 0; n < 3; n++) begin
            cycle('0, '0, 1'b0, '0);
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rr_tail cyc=%0d got=%h exp=%h", m_c, obs_vec(), exp_vec());
            end
            checks++;
        end
    endtask

    task automatic test_single_word();
        int acc_c, first_out, nvalid;
        logic [W-1:0] seen_data;
        logic [TW-1:0] seen_tag;
        first_out = -1; nvalid = 0; seen_data = '0; seen_tag = '0;
        cycle('0, '0, 1'b1, CW'(3));
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL single_cfg cyc=%0d got=%h exp=%h", m_c, obs_vec(), exp_vec());
        end
        checks++;
        cycle(4'b0100, 32'h00A5_0000, 1'b0, '0);
        acc_c = m_c;
        if (g_obs !== 4'b0100) begin
            errors++;
            $display("FAIL single_grant got=%b exp=0100", g_obs);
        end
        checks++;
        for (int n = 0; n < 6; n++) begin
            if (n > 0) cycle('0, '0, 1'b0, '0);
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL single_model cyc=%0d got=%h exp=%h", m_c, obs_vec(), exp_vec());
            end
            checks++;
            if (out_valid) begin
                nvalid++;
                if (first_out < 0) begin first_out = m_c; seen_data = out_data; seen_tag = out_tag; end
            end
        end
        if (nvalid != 1 || first_out - acc_c + 1 != 3 || seen_data !== 8'hA5 || seen_tag !== 2'd2) begin
            errors++;
            $display("FAIL single_word got n=%0d lat=%0d d=%h t=%0d exp n=1 lat=3 d=a5 t=2",
                     nvalid, first_out - acc_c + 1, seen_data, seen_tag);
        end
        checks++;
    endtask

    task automatic test_clamp();
        int cds[2]  = '{0, MAXD + 3};
        int lats[2] = '{1, MAXD};
        for (int c = 0; c < 2; c++) begin
            int acc_c, first_out;
            first_out = -1;
            cycle('0, '0, 1'b1, CW'(cds[c]));
            cycle(R'(1) << $urandom_range(0, R-1), $urandom, 1'b0, '0);
            acc_c = m_c;
            for (int n = 0; n < MAXD + 2; n++) begin
                if (n > 0) cycle('0, '0, 1'b0, '0);
                if (obs_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL clamp_model cyc=%0d got=%h exp=%h", m_c, obs_vec(), exp_vec());
                end
                checks++;
                if (out_valid && first_out < 0) first_out = m_c;
            end
            if (first_out < 0 || first_out - acc_c + 1 != lats[c]) begin
                errors++;
                $display("FAIL clamp_latency cfg=%0d got=%0d exp=%0d", cds[c],
                         (first_out < 0) ? -1 : first_out - acc_c + 1, lats[c]);
            end
            checks++;
        end
    endtask

    task automatic test_reconfig();
        int acc_c, first_out;
        cycle('0, '0, 1'b1, CW'(4));
        for (int n = 0; n < 3; n++) begin
            cycle(R'($urandom_range(1, 15)), $urandom, 1'b0, '0);
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reconf_fill cyc=%0d got=%h exp=%h", m_c, obs_vec(), exp_vec());
            end
            checks++;
        end
        cycle('1, $urandom, 1'b1, CW'(2));
        if (g_obs !== '0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reconf_load got g=%b busy=%b exp g=0000 busy=1", g_obs, busy);
        end
        checks++;
        for (int n = 0; n < 10; n++) begin
            cycle(R'($urandom_range(0, 15)), $urandom, 1'b0, '0);
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reconf_drain cyc=%0d got=%h exp=%h", m_c, obs_vec(), exp_vec());
            end
            checks++;
        end
        for (int n = 0; n < 4; n++) cycle('0, '0, 1'b0, '0);
        first_out = -1;
        cycle(4'b1000, $urandom, 1'b0, '0);
        acc_c = m_c;
        for (int n = 0; n < 4; n++) begin
            if (n > 0) cycle('0, '0, 1'b0, '0);
            if (out_valid && first_out < 0) first_out = m_c;
        end
        if (first_out < 0 || first_out - acc_c + 1 != 2) begin
            errors++;
            $display("FAIL reconf_new_depth got=%0d exp=2",
                     (first_out < 0) ? -1 : first_out - acc_c + 1);
        end
        checks++;
    endtask

    task automatic test_simultaneous();
        int acc_c, first_out;
        logic [R*W-1:0] din;
        din = $urandom;
        first_out = -1;
        cycle(4'b0010, din, 1'b1, CW'(2));
        if (g_obs !== '0) begin
            errors++;
            $display("FAIL simul_grant_blocked got=%b exp=0000", g_obs);
        end
        checks++;
        cycle(4'b0010, din, 1'b0, '0);
        acc_c = m_c;
        if (g_obs !== 4'b0010) begin
            errors++;
            $display("FAIL simul_grant_next got=%b exp=0010", g_obs);
        end
        checks++;
        for (int n = 0; n < 4; n++) begin
            if (n > 0) cycle('0, '0, 1'b0, '0);
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL simul_model cyc=%0d got=%h exp=%h", m_c, obs_vec(), exp_vec());
            end
            checks++;
            if (out_valid && first_out < 0) first_out = m_c;
        end
        if (first_out < 0 || first_out - acc_c + 1 != 2) begin
            errors++;
            $display("FAIL simul_latency got=%0d exp=2", (first_out < 0) ? -1 : first_out - acc_c + 1);
        end
        checks++;
    endtask

    task automatic test_reset_midflight();
        logic [R-1:0] r, low;
        cycle('0, '0, 1'b1, CW'(5));
        for (int n = 0; n < 4; n++) cycle(R'($urandom_range(1, 15)), $urandom, 1'b0, '0);
        cycle('0, '0, 1'b0, '0);
        if (out_valid !== 1'b1 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL midrst_pre got=%h exp=%h", obs_vec(), exp_vec());
        end
        checks++;
        #1 rst = 1'b0;
        #1;
        if ({out_valid, out_data, busy} !== '0) begin
            errors++;
            $display("FAIL midrst_async got v=%b d=%h busy=%b exp all zero", out_valid, out_data, busy);
        end
        checks++;
        model_reset();
        #1 rst = 1'b1;
        @(negedge clk);
        for (int n = 0; n < 8; n++) begin
            cycle('0, '0, 1'b0, '0);
            if (obs_vec() !== exp_vec() || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midrst_quiet cyc=%0d got=%h exp=%h", m_c, obs_vec(), exp_vec());
            end
            checks++;
        end
        r = R'($urandom_range(1, 15));
        low = '0;
        for (int i = R-1; i >= 0; i--) if (r[i]) low = R'(1) << i;
        cycle(r, $urandom, 1'b0, '0);
        if (g_obs !== low) begin
            errors++;
            $display("FAIL midrst_first_grant req=%b got=%b exp=%b", r, g_obs, low);
        end
        checks++;
        for (int n = 0; n < 3; n++) cycle('0, '0, 1'b0, '0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            logic ld;
            ld = (m_mode != 2) && ($urandom_range(0, 15) == 0);
            cycle(R'($urandom_range(0, 15)), $urandom, ld, CW'($urandom_range(0, 15)));
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h exp=%h", m_c, obs_vec(), exp_vec());
            end
            checks++;
        end
        for (int n = 0; n < 12; n++) begin
            cycle('0, '0, 1'b0, '0);
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_tail cyc=%0d got=%h exp=%h", m_c, obs_vec(), exp_vec());
            end
            checks++;
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_word();
        test_clamp();
        test_reconfig();
        test_simultaneous();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
